// File: rtl/if_fetch_redirect_pkg.sv
// Shared next-PC select codes and reset constants for the IF stage and the ID controller.
package if_fetch_redirect_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_op_e;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_redirect_npc_calc.sv
// Combinational next-PC selection: sequential, branch, jump and register-jump targets.
module npc_calc
  import if_fetch_redirect_pkg::*;
(
  input  logic [31:0] pc_f,
  input  logic [31:0] pc_d,
  input  logic [31:0] instr_d,
  input  logic [1:0]  npc_op,
  input  logic        br_taken,
  input  logic        nullify,
  input  logic [31:0] jr_target,
  input  logic        valid_d,
  output logic [31:0] npc
);

  logic [31:0] seq_tgt;
  logic [31:0] pc_d4;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;

  assign seq_tgt = pc_f + 32'd4;
  assign pc_d4   = pc_d + 32'd4;
  assign br_tgt  = pc_d4 + {{14{instr_d[15]}}, instr_d[15:0], 2'b00};
  assign j_tgt   = {pc_d4[31:28], instr_d[25:0], 2'b00};

  always_comb begin
    npc = seq_tgt;
    if (valid_d && !nullify) begin
      unique case (npc_op_e'(npc_op))
        NPC_BR:  npc = br_taken ? br_tgt : seq_tgt;
        NPC_J:   npc = j_tgt;
        NPC_JR:  npc = jr_target;
        default: npc = seq_tgt;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_redirect.sv
// IF stage: PC register, IF/ID pipeline register, delay-slot squash and sticky protocol check.
module if_fetch_redirect
  import if_fetch_redirect_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] instr_f,
  input  logic [1:0]  npc_op,
  input  logic        br_taken,
  input  logic        nullify,
  input  logic [31:0] jr_target,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        valid_d,
  output logic [31:0] npc,
  output logic        proto_err
);

  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] instr_d_q, instr_d_d;
  logic [31:0] pc_d_q, pc_d_d;
  logic        valid_d_q, valid_d_d;
  logic        proto_err_q, proto_err_d;
  logic        decide;
  logic        violation;

  // ID decisions only count when a real instruction sits in ID and it is not held.
  assign decide = valid_d_q && !stall;

  npc_calc u_npc_calc (
    .pc_f      (pc_f_q),
    .pc_d      (pc_d_q),
    .instr_d   (instr_d_q),
    .npc_op    (npc_op),
    .br_taken  (br_taken),
    .nullify   (nullify),
    .jr_target (jr_target),
    .valid_d   (decide),
    .npc       (npc)
  );

  assign violation = (nullify && br_taken)
                   || (nullify && (npc_op_e'(npc_op) != NPC_BR))
                   || ((npc_op_e'(npc_op) == NPC_JR) && (jr_target[1:0] != 2'b00));

  always_comb begin
    pc_f_d      = pc_f_q;
    instr_d_d   = instr_d_q;
    pc_d_d      = pc_d_q;
    valid_d_d   = valid_d_q;
    proto_err_d = proto_err_q;
    if (!stall) begin
      if (nullify && valid_d_q) begin
        pc_f_d    = pc_f_q + 32'd4;
        instr_d_d = NOP_INSTR;
        pc_d_d    = pc_f_q;
        valid_d_d = 1'b0;
      end else begin
        pc_f_d    = npc;
        instr_d_d = instr_f;
        pc_d_d    = pc_f_q;
        valid_d_d = 1'b1;
      end
      if (decide && violation) proto_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f_q      <= RESET_PC;
      instr_d_q   <= NOP_INSTR;
      pc_d_q      <= '0;
      valid_d_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      pc_f_q      <= pc_f_d;
      instr_d_q   <= instr_d_d;
      pc_d_q      <= pc_d_d;
      valid_d_q   <= valid_d_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign pc_f      = pc_f_q;
  assign instr_d   = instr_d_q;
  assign pc_d      = pc_d_q;
  assign pc8_d     = pc_d_q + 32'd8;
  assign valid_d   = valid_d_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_if_fetch_redirect.sv
// Directed bench for if_fetch_redirect: reset, sequential fetch, branches, squash, stall, jumps.
module tb_if_fetch_redirect;

  logic        clk = 1'b0;
  logic        reset, stall, br_taken, nullify;
  logic [1:0]  npc_op;
  logic [31:0] instr_f, jr_target;
  logic [31:0] pc_f, instr_d, pc_d, pc8_d, npc;
  logic        valid_d, proto_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  if_fetch_redirect #(
    .RESET_PC  (32'h0000_3000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .instr_f   (instr_f),
    .npc_op    (npc_op),
    .br_taken  (br_taken),
    .nullify   (nullify),
    .jr_target (jr_target),
    .pc_f      (pc_f),
    .instr_d   (instr_d),
    .pc_d      (pc_d),
    .pc8_d     (pc8_d),
    .valid_d   (valid_d),
    .npc       (npc),
    .proto_err (proto_err)
  );

  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h3000: imem = 32'h0800_0C10;
      32'h3004: imem = 32'h1000_FFFF;
      32'h3008: imem = 32'h2408_0001;
      32'h3010: imem = 32'h5C00_0003;
      32'h3018: imem = 32'h1000_0004;
      32'h301C: imem = 32'h2409_0002;
      default:  imem = 32'hACE0_0000 | {16'h0, a[15:0]};
    endcase
  endfunction

  assign instr_f = imem(pc_f);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ifid(input string tag, input logic [31:0] epcf, input logic [31:0] epcd,
                      input logic [31:0] einstr, input logic ev);
    chk({tag, ".pc_f"}, pc_f, epcf);
    chk({tag, ".pc_d"}, pc_d, epcd);
    chk({tag, ".instr_d"}, instr_d, einstr);
    chk({tag, ".valid_d"}, {31'h0, valid_d}, {31'h0, ev});
  endtask

  initial begin
    reset = 1'b1; stall = 1'b1; npc_op = 2'b00; br_taken = 1'b0;
    nullify = 1'b0; jr_target = 32'h0;
    #2;
    step(); step();
    ifid("reset", 32'h3000, 32'h0, 32'h0, 1'b0);
    chk("reset.proto_err", {31'h0, proto_err}, 32'h0);

    // Sequential fetch
    reset = 1'b0; stall = 1'b0;
    step();
    ifid("seq1", 32'h3004, 32'h3000, 32'h0800_0C10, 1'b1);
    chk("seq1.pc8_d", pc8_d, 32'h3008);
    step();
    ifid("seq2", 32'h3008, 32'h3004, 32'h1000_FFFF, 1'b1);
    chk("seq2.pc8_d", pc8_d, 32'h300C);

    // Taken BEQ with offset -1 word: target 0x3004, delay slot from 0x3008
    npc_op = 2'b01; br_taken = 1'b1;
    #1 chk("beq.npc", npc, 32'h3004);
    step();
    ifid("beq", 32'h3004, 32'h3008, 32'h2408_0001, 1'b1);

    npc_op = 2'b00; br_taken = 1'b0;
    step(); step(); step(); step();
    ifid("seq_to_bgtzl", 32'h3014, 32'h3010, 32'h5C00_0003, 1'b1);

    // BGTZL not taken: squash delay slot
    npc_op = 2'b01; nullify = 1'b1;
    #1 chk("bgtzl.npc", npc, 32'h3018);
    step();
    ifid("bgtzl", 32'h3018, 32'h3014, 32'h0, 1'b0);
    chk("bgtzl.proto_err", {31'h0, proto_err}, 32'h0);

    // Nullify + br_taken with valid_d=0 is ignored entirely
    br_taken = 1'b1;
    #1 chk("nullv0.npc", npc, 32'h301C);
    step();
    ifid("nullv0", 32'h301C, 32'h3018, 32'h1000_0004, 1'b1);
    chk("nullv0.proto_err", {31'h0, proto_err}, 32'h0);

    // Stall across a taken-branch decision (target 0x302C)
    nullify = 1'b0; npc_op = 2'b01; br_taken = 1'b1; stall = 1'b1;
    step();
    ifid("stall1", 32'h301C, 32'h3018, 32'h1000_0004, 1'b1);
    chk("stall1.pc8_d", pc8_d, 32'h3020);
    nullify = 1'b1;
    step();
    ifid("stall2", 32'h301C, 32'h3018, 32'h1000_0004, 1'b1);
    chk("stall2.proto_err", {31'h0, proto_err}, 32'h0);
    nullify = 1'b0; stall = 1'b0;
    #1 chk("unstall.npc", npc, 32'h302C);
    step();
    ifid("unstall", 32'h302C, 32'h301C, 32'h2409_0002, 1'b1);

    // Aligned JR back to 0x3000, then J with index 0xC10 -> 0x3040
    npc_op = 2'b11; br_taken = 1'b0; jr_target = 32'h3000;
    step();
    ifid("jr_ok", 32'h3000, 32'h302C, 32'hACE0_302C, 1'b1);
    chk("jr_ok.proto_err", {31'h0, proto_err}, 32'h0);
    npc_op = 2'b00;
    step();
    ifid("pre_j", 32'h3004, 32'h3000, 32'h0800_0C10, 1'b1);
    npc_op = 2'b10;
    #1 chk("j.npc", npc, 32'h3040);
    step();
    ifid("j", 32'h3040, 32'h3004, 32'h1000_FFFF, 1'b1);
    chk("j.proto_err", {31'h0, proto_err}, 32'h0);

    // Misaligned JR: PC still follows, protocol flag sets and sticks
    npc_op = 2'b11; jr_target = 32'h3001;
    step();
    chk("jr_bad.pc_f", pc_f, 32'h3001);
    chk("jr_bad.proto_err", {31'h0, proto_err}, 32'h1);
    npc_op = 2'b00;
    step();
    chk("sticky.pc_f", pc_f, 32'h3005);
    chk("sticky.proto_err", {31'h0, proto_err}, 32'h1);

    // Reset discards a pending redirect and clears the flag
    npc_op = 2'b11; jr_target = 32'h4000; reset = 1'b1;
    step();
    ifid("rst2", 32'h3000, 32'h0, 32'h0, 1'b0);
    chk("rst2.proto_err", {31'h0, proto_err}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
